splitter: RTL and testbench
===========================

# splitter

Receive-side counterpart of the combiner: decodes the single-wire pulse-width line (`sg_out` from the combiner) back into bytes. Synchronises the line, measures every low pulse, classifies it as a 1 or 0 bit, assembles bits MSB-first into bytes and queues them in a small FIFO behind a valid/ready port. Frame boundaries are recovered from idle-high gaps; width violations and overflow are flagged.

## Interface
- `SHORT_MIN`, 4: minimum low-run clocks classified as bit 1
- `SHORT_MAX`, 9: maximum low-run clocks classified as bit 1
- `LONG_MIN`, 13: minimum low-run clocks classified as bit 0
- `LONG_MAX`, 22: maximum low-run clocks classified as bit 0
- `IDLE_LEN`, 40: high-run clocks that end a frame
- `FIFO_DEPTH`, 4: byte FIFO entries (power of two)
- `CNT_W`, 8: run-length counter width
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `sg_in` in 1: encoded line, idle high, asynchronous to clk
- `m_data` out 8: decoded byte (FIFO head)
- `m_valid` out 1: FIFO non-empty
- `m_ready` in 1: consumer accepts head when `m_valid & m_ready`
- `fifo_level` out $clog2(FIFO_DEPTH)+1: bytes queued
- `frame_start` out 1: one-cycle pulse, first falling edge after idle
- `frame_end` out 1: one-cycle pulse, idle gap reached inside a frame
- `sym_err` out 1: one-cycle pulse, low run outside both windows
- `frame_err` out 1: one-cycle pulse, frame ended with partial byte
- `ovf` out 1: sticky, byte dropped on full FIFO; cleared only by `rst`
- `busy` out 1: state ≠ IDLE

## Operation
- `sg_in` passes a 2-flop synchroniser (reset to 1), then one delay flop for edge detection.
- States: IDLE, LOW, HIGH, RESYNC (reset → IDLE).
- IDLE: falling edge → LOW, `low_cnt`=1, pulse `frame_start`, clear bit index and shift register.
- LOW: `low_cnt` increments, saturating at 2^CNT_W−1. On rising edge: count in [SHORT_MIN,SHORT_MAX] → shift in 1; in [LONG_MIN,LONG_MAX] → shift in 0; then → HIGH, `high_cnt`=1. Any other count → pulse `sym_err`, discard partial byte, → RESYNC.
- HIGH: `high_cnt` increments. Falling edge → LOW, `low_cnt`=1. `high_cnt`==IDLE_LEN → pulse `frame_end`; if bit index ≠0 also pulse `frame_err` and discard partial byte; → IDLE.
- RESYNC: ignores edges; a falling edge resets `high_cnt` to 0; `high_cnt`==IDLE_LEN → IDLE with no `frame_end`.
- 8th accepted bit: byte pushed to FIFO, bit index wraps to 0.
- FIFO: push allowed when not full or when a pop occurs the same cycle; otherwise byte dropped and `ovf` set. No fall-through: an empty FIFO shows `m_valid` the cycle after the push. Simultaneous push and pop leaves `fifo_level` unchanged.
- Reset mid-frame: all state, FIFO contents and flags cleared immediately; the line is re-acquired only after the next falling edge from IDLE.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `fifo_level`=0, `frame_start`/`frame_end`/`sym_err`/`frame_err`/`ovf`/`busy`=0.
- Edge latency: 3 clk from the first clk edge sampling the new `sg_in` level to state or pulse update.
- Byte latency: `m_valid` rises 4 clk after the first clk edge that samples `sg_in` high at the end of the 8th pulse (6 with the filter).
- Run counts are measured on the synchronised line, so a low run of N clocks at the pin gives `low_cnt`=N.

## Configuration
- `SPLITTER_GLITCH_FILTER_EN` defined: 3-sample majority filter after the synchroniser, adding 2 clk latency. Isolated single-cycle glitches are removed before edge detection.
- Undefined: no filter. A 1-clk glitch produces an out-of-window low run, which gives `sym_err` → RESYNC.

## Structure
- `combiner_pkg`: line-code timing constants shared with the combiner (start/low/high/stop periods, default windows, IDLE_LEN) and the splitter state enum.
- Sub-module `byte_fifo`: synchronous FIFO, parameter DEPTH, ports push/pop/din/dout/full/empty/level.

## Test plan
- Frame of byte 0xA5 (pulses 6/17 clk low, 21 high), then 50 clk idle → `frame_start`, `m_data`=0xA5 with `m_valid`, `frame_end`, no errors.
- Low pulse of 11 clk mid-byte → `sym_err`, no byte pushed. After 40 clk high, next frame 0x3C decodes correctly.
- 5 bits then idle → `frame_end` and `frame_err` in the same cycle, `fifo_level` stays 0.
- 6 bytes with `m_ready`=0 → `fifo_level`=4, `ovf`=1, head byte = first byte. Then raising `m_ready` drains 4 bytes in order.
- Push and pop in the same cycle at full → no `ovf`, level stays 4.
- `rst` asserted at bit 4 of byte 2 → all outputs 0 next edge. The following frame 0xFF decodes correctly.

Source files
------------

// File: rtl/combiner_pkg.sv
// -----------------------------------------------------------------------------
// combiner_pkg
// Line-code timing constants shared by the combiner (transmit) and the
// splitter (receive), the splitter state encoding and a small window helper.
//
// Line code: idle high. Every bit is one low pulse followed by a high gap.
//   short low pulse -> bit 1, long low pulse -> bit 0.
// A high run of IDLE_LEN clocks ends a frame.
// -----------------------------------------------------------------------------
package combiner_pkg;

    // Nominal periods produced by the combiner, in clk cycles.
    localparam int START_LOW_CLKS = 6;   // first pulse of a frame is an ordinary bit
    localparam int ONE_LOW_CLKS   = 6;   // low time of a 1
    localparam int ZERO_LOW_CLKS  = 17;  // low time of a 0
    localparam int BIT_HIGH_CLKS  = 21;  // high gap between bits
    localparam int STOP_HIGH_CLKS = 50;  // high time after the last bit of a frame

    // Default receive windows; wide enough to absorb synchroniser jitter.
    localparam int DEF_SHORT_MIN = 4;
    localparam int DEF_SHORT_MAX = 9;
    localparam int DEF_LONG_MIN  = 13;
    localparam int DEF_LONG_MAX  = 22;
    localparam int DEF_IDLE_LEN  = 40;

    typedef enum logic [1:0] {
        SPL_IDLE   = 2'd0,
        SPL_LOW    = 2'd1,
        SPL_HIGH   = 2'd2,
        SPL_RESYNC = 2'd3
    } splitter_state_t;

    // Inclusive range test on a run length.
    function automatic logic in_window(input int cnt, input int lo, input int hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/splitter_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO, no fall-through: a byte written into an empty FIFO
// becomes visible on dout the cycle after the push.
// A push is accepted when the FIFO is not full, or when a pop happens in the
// same cycle (the slot being freed is reused). A push that is not accepted is
// silently dropped here; the parent decides how to flag it.
//
// Parameters
//   DEPTH  entries, power of two, >= 2
// Ports
//   clk, rst  clock, asynchronous active-high reset
//   push, din write request and data
//   pop       read request (ignored when empty)
//   dout      head entry (0 after reset)
//   full      level == DEPTH
//   empty     level == 0
//   level     entries held
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    logic do_push;
    logic do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout  = mem_q[rd_ptr_q];
    assign level = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/splitter.sv
// -----------------------------------------------------------------------------
// splitter
// Decodes the combiner's single-wire pulse-width line back into bytes.
// The line is synchronised, every low run is measured and classified
// (short -> 1, long -> 0), bits are assembled MSB-first and each completed
// byte is queued in a small FIFO behind a valid/ready port. Idle-high gaps
// delimit frames.
//
// Handshake: m_valid is high while the FIFO holds a byte; the head byte on
// m_data is consumed on every clock edge where m_valid & m_ready are both high.
// m_data is stable while m_valid is high and m_ready is low.
//
// Build option
//   SPLITTER_GLITCH_FILTER_EN  3-sample majority filter after the synchroniser
//                              (removes single-cycle glitches, +2 clk latency)
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   sg_in        encoded line, idle high, asynchronous to clk
//   m_data       FIFO head byte
//   m_valid      FIFO non-empty
//   m_ready      consumer ready
//   fifo_level   bytes queued
//   frame_start  pulse: first falling edge after idle
//   frame_end    pulse: idle gap reached inside a frame
//   sym_err      pulse: low run outside both windows
//   frame_err    pulse: frame ended with a partial byte
//   ovf          sticky: byte dropped on full FIFO (cleared by rst only)
//   busy         decoder not in IDLE
// -----------------------------------------------------------------------------
module splitter
    import combiner_pkg::*;
#(
    parameter int SHORT_MIN  = DEF_SHORT_MIN,
    parameter int SHORT_MAX  = DEF_SHORT_MAX,
    parameter int LONG_MIN   = DEF_LONG_MIN,
    parameter int LONG_MAX   = DEF_LONG_MAX,
    parameter int IDLE_LEN   = DEF_IDLE_LEN,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sg_in,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic                          sym_err,
    output logic                          frame_err,
    output logic                          ovf,
    output logic                          busy
);

    // ---------------------------------------------------------------- input
    logic sync1_q, sync2_q;
    logic line;       // synchronised (and optionally filtered) line
    logic line_d_q;   // one-cycle delayed copy for edge detection

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sg_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SPLITTER_GLITCH_FILTER_EN
    logic tap1_q, tap2_q, filt_q;

    // Majority of the current and two previous samples, registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap1_q <= 1'b1;
            tap2_q <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            tap1_q <= sync2_q;
            tap2_q <= tap1_q;
            filt_q <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_d_q <= 1'b1;
        end else begin
            line_d_q <= line;
        end
    end

    logic fall, rise;
    assign fall = line_d_q & ~line;
    assign rise = ~line_d_q & line;

    // ---------------------------------------------------------------- decoder
    splitter_state_t state_q, state_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q, push_data_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;
    logic             se_q, se_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q;

    logic is_one, is_zero;
    assign is_one  = in_window(int'(low_cnt_q), SHORT_MIN, SHORT_MAX);
    assign is_zero = in_window(int'(low_cnt_q), LONG_MIN, LONG_MAX);

    localparam logic [CNT_W-1:0] IDLE_CNT = CNT_W'(IDLE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        high_cnt_d  = high_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        se_d        = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            SPL_IDLE: begin
                if (fall) begin
                    state_d   = SPL_LOW;
                    low_cnt_d = CNT_W'(1);
                    fs_d      = 1'b1;
                    bit_idx_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end

            SPL_LOW: begin
                if (rise) begin
                    if (is_one || is_zero) begin
                        shift_d    = {shift_q[6:0], is_one};
                        bit_idx_d  = bit_idx_q + 3'd1;   // wraps to 0 after the 8th bit
                        if (bit_idx_q == 3'd7) begin
                            push_d      = 1'b1;
                            push_data_d = {shift_q[6:0], is_one};
                        end
                        state_d    = SPL_HIGH;
                        high_cnt_d = CNT_W'(1);
                    end else begin
                        se_d       = 1'b1;
                        bit_idx_d  = 3'd0;
                        shift_d    = 8'h00;
                        state_d    = SPL_RESYNC;
                        high_cnt_d = CNT_W'(1);
                    end
                end else if (low_cnt_q != CNT_MAX) begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end

            SPL_HIGH: begin
                // A falling edge wins over the idle check: the frame goes on.
                if (fall) begin
                    state_d   = SPL_LOW;
                    low_cnt_d = CNT_W'(1);
                end else if (high_cnt_q == IDLE_CNT) begin
                    fe_d    = 1'b1;
                    state_d = SPL_IDLE;
                    if (bit_idx_q != 3'd0) begin
                        ferr_d    = 1'b1;
                        bit_idx_d = 3'd0;
                        shift_d   = 8'h00;
                    end
                end else if (high_cnt_q != CNT_MAX) begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end

            SPL_RESYNC: begin
                // Only an unbroken high run of IDLE_LEN releases the decoder;
                // low time does not count towards it.
                if (fall) begin
                    high_cnt_d = '0;
                end else if (high_cnt_q == IDLE_CNT) begin
                    state_d = SPL_IDLE;
                end else if (line && (high_cnt_q != CNT_MAX)) begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = SPL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SPL_IDLE;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            se_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
            se_q        <= se_d;
            ferr_q      <= ferr_d;
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic fifo_full, fifo_empty, pop;

    assign pop = ~fifo_empty & m_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop),
        .din   (push_data_q),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A pop in the same cycle frees a slot, so only a push at full without
    // a pop loses a byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign m_valid     = ~fifo_empty;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign sym_err     = se_q;
    assign frame_err   = ferr_q;
    assign ovf         = ovf_q;
    assign busy        = (state_q != SPL_IDLE);

endmodule

// File: tb/tb_splitter.sv
// -----------------------------------------------------------------------------
// tb_splitter
// Directed bench for the splitter. The line is driven on the falling clock
// edge, outputs are sampled on the falling edge. Pulse outputs are counted by
// a monitor; each scenario compares the count deltas it expects.
// -----------------------------------------------------------------------------
module tb_splitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sg_in = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [2:0] fifo_level;
    logic       frame_start, frame_end, sym_err, frame_err, ovf, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Pulse counters, written only by the monitor.
    int fs_cnt = 0;
    int fe_cnt = 0;
    int se_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;

    // Negedge of the cycle in which m_ready must be high so that the FIFO
    // write of the final byte and a pop share one clock edge, counted from
    // the negedge where the line is released high.
`ifdef SPLITTER_GLITCH_FILTER_EN
    localparam int POP_AT = 5;
`else
    localparam int POP_AT = 3;
`endif

    always #5 clk = ~clk;

    splitter dut (
        .clk         (clk),
        .rst         (rst),
        .sg_in       (sg_in),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .sym_err     (sym_err),
        .frame_err   (frame_err),
        .ovf         (ovf),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (sym_err) se_cnt++;
        if (frame_err) ferr_cnt++;
        if (frame_end && frame_err) both_cnt++;
    end

    // ------------------------------------------------------------ drivers
    task automatic idle(input int n);
        sg_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int low_n, input int high_n, input int pop_at);
        sg_in = 1'b0;
        repeat (low_n) @(negedge clk);
        sg_in = 1'b1;
        for (int i = 1; i <= high_n; i++) begin
            @(negedge clk);
            m_ready = (i == pop_at);
        end
    endtask

    // Sends the top n bits of b, MSB first: 1 = 6 clk low, 0 = 17 clk low.
    task automatic send_bits(input logic [7:0] b, input int n, input int pop_last);
        for (int i = 7; i > 7 - n; i--) begin
            send_pulse(b[i] ? 6 : 17, 21, (i == 8 - n) ? pop_last : 0);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        @(negedge clk);
        vec_cnt++; if (m_data !== 8'h00) begin err_cnt++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        vec_cnt++; if (frame_start !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        vec_cnt++; if (frame_end !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_end: got %b want 0", frame_end); end
        vec_cnt++; if (sym_err !== 1'b0) begin err_cnt++; $display("FAIL reset_sym_err: got %b want 0", sym_err); end
        vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_single_byte();
        int fs0, fe0, se0, ferr0;
        fs0 = fs_cnt; fe0 = fe_cnt; se0 = se_cnt; ferr0 = ferr_cnt;
        send_bits(8'hA5, 8, 0);
        idle(50);
        vec_cnt++; if (fs_cnt - fs0 !== 1) begin err_cnt++; $display("FAIL a5_frame_start: got %0d want 1", fs_cnt - fs0); end
        vec_cnt++; if (fe_cnt - fe0 !== 1) begin err_cnt++; $display("FAIL a5_frame_end: got %0d want 1", fe_cnt - fe0); end
        vec_cnt++; if (se_cnt - se0 !== 0) begin err_cnt++; $display("FAIL a5_sym_err: got %0d want 0", se_cnt - se0); end
        vec_cnt++; if (ferr_cnt - ferr0 !== 0) begin err_cnt++; $display("FAIL a5_frame_err: got %0d want 0", ferr_cnt - ferr0); end
        vec_cnt++; if (m_valid !== 1'b1) begin err_cnt++; $display("FAIL a5_m_valid: got %b want 1", m_valid); end
        vec_cnt++; if (m_data !== 8'hA5) begin err_cnt++; $display("FAIL a5_m_data: got %h want a5", m_data); end
        vec_cnt++; if (fifo_level !== 3'd1) begin err_cnt++; $display("FAIL a5_level: got %0d want 1", fifo_level); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL a5_busy: got %b want 0", busy); end
        pop_one();
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL a5_popped: got %b want 0", m_valid); end
    endtask

    task automatic test_sym_err();
        int se0, fe0;
        se0 = se_cnt; fe0 = fe_cnt;
        send_bits(8'hA0, 3, 0);
        send_pulse(11, 50, 0);   // 11 clk low sits between the two windows
        vec_cnt++; if (se_cnt - se0 !== 1) begin err_cnt++; $display("FAIL sym_err_pulse: got %0d want 1", se_cnt - se0); end
        vec_cnt++; if (fe_cnt - fe0 !== 0) begin err_cnt++; $display("FAIL sym_err_no_frame_end: got %0d want 0", fe_cnt - fe0); end
        vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL sym_err_level: got %0d want 0", fifo_level); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL sym_err_resync_done: got %b want 0", busy); end
        send_bits(8'h3C, 8, 0);
        idle(50);
        vec_cnt++; if (m_data !== 8'h3C) begin err_cnt++; $display("FAIL 3c_m_data: got %h want 3c", m_data); end
        vec_cnt++; if (fifo_level !== 3'd1) begin err_cnt++; $display("FAIL 3c_level: got %0d want 1", fifo_level); end
        vec_cnt++; if (se_cnt - se0 !== 1) begin err_cnt++; $display("FAIL 3c_sym_err: got %0d want 1", se_cnt - se0); end
        pop_one();
    endtask

    task automatic test_partial_frame();
        int fe0, ferr0, both0;
        fe0 = fe_cnt; ferr0 = ferr_cnt; both0 = both_cnt;
        send_bits(8'hB0, 5, 0);
        idle(50);
        vec_cnt++; if (fe_cnt - fe0 !== 1) begin err_cnt++; $display("FAIL partial_frame_end: got %0d want 1", fe_cnt - fe0); end
        vec_cnt++; if (ferr_cnt - ferr0 !== 1) begin err_cnt++; $display("FAIL partial_frame_err: got %0d want 1", ferr_cnt - ferr0); end
        vec_cnt++; if (both_cnt - both0 !== 1) begin err_cnt++; $display("FAIL partial_same_cycle: got %0d want 1", both_cnt - both0); end
        vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL partial_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        for (int k = 0; k < 6; k++) send_bits(bytes[k], 8, 0);
        idle(50);
        vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        vec_cnt++; if (m_data !== 8'h11) begin err_cnt++; $display("FAIL ovf_head: got %h want 11", m_data); end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if (m_valid !== 1'b1 || m_data !== bytes[k]) begin
                err_cnt++; $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, bytes[k]);
            end
            pop_one();
        end
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained: got %b want 0", m_valid); end
        vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] bytes [5];
        bytes[0] = 8'h81; bytes[1] = 8'h42; bytes[2] = 8'h24;
        bytes[3] = 8'h18; bytes[4] = 8'hE7;
        pulse_reset();
        idle(5);
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL pp_ovf_cleared: got %b want 0", ovf); end
        for (int k = 0; k < 4; k++) send_bits(bytes[k], 8, 0);
        send_bits(bytes[4], 8, POP_AT);
        idle(50);
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL pp_no_ovf: got %b want 0", ovf); end
        vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL pp_level: got %0d want 4", fifo_level); end
        for (int k = 1; k < 5; k++) begin
            vec_cnt++;
            if (m_valid !== 1'b1 || m_data !== bytes[k]) begin
                err_cnt++; $display("FAIL pp_drain_%0d: got v=%b d=%h want v=1 d=%h", k, m_valid, m_data, bytes[k]);
            end
            pop_one();
        end
        vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL pp_empty: got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid_frame();
        int fs0, se0, ferr0;
        send_bits(8'h5A, 8, 0);
        send_bits(8'hC0, 4, 0);
        sg_in = 1'b0;                 // inside the low pulse of bit 4
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        vec_cnt++; if (m_data !== 8'h00) begin err_cnt++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        sg_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(50);
        fs0 = fs_cnt; se0 = se_cnt; ferr0 = ferr_cnt;
        send_bits(8'hFF, 8, 0);
        idle(50);
        vec_cnt++; if (m_data !== 8'hFF) begin err_cnt++; $display("FAIL ff_m_data: got %h want ff", m_data); end
        vec_cnt++; if (fifo_level !== 3'd1) begin err_cnt++; $display("FAIL ff_level: got %0d want 1", fifo_level); end
        vec_cnt++; if (fs_cnt - fs0 !== 1) begin err_cnt++; $display("FAIL ff_frame_start: got %0d want 1", fs_cnt - fs0); end
        vec_cnt++; if (se_cnt - se0 !== 0 || ferr_cnt - ferr0 !== 0) begin
            err_cnt++; $display("FAIL ff_errors: got se=%0d ferr=%0d want 0 0", se_cnt - se0, ferr_cnt - ferr0);
        end
        pop_one();
    endtask

    task automatic test_glitch();
        int fs0, se0;
        fs0 = fs_cnt; se0 = se_cnt;
        sg_in = 1'b0;
        @(negedge clk);
        idle(10);
`ifdef SPLITTER_GLITCH_FILTER_EN
        vec_cnt++; if (se_cnt - se0 !== 0) begin err_cnt++; $display("FAIL glitch_sym_err: got %0d want 0", se_cnt - se0); end
        vec_cnt++; if (fs_cnt - fs0 !== 0) begin err_cnt++; $display("FAIL glitch_frame_start: got %0d want 0", fs_cnt - fs0); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy: got %b want 0", busy); end
`else
        vec_cnt++; if (se_cnt - se0 !== 1) begin err_cnt++; $display("FAIL glitch_sym_err: got %0d want 1", se_cnt - se0); end
        vec_cnt++; if (fs_cnt - fs0 !== 1) begin err_cnt++; $display("FAIL glitch_frame_start: got %0d want 1", fs_cnt - fs0); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_resync: got %b want 1", busy); end
`endif
        idle(50);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_recovered: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_sym_err();
        test_partial_frame();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
